// File: rtl/icache_refill_ctrl_pkg.sv
// Shared types and widths for the instruction-cache refill path.
// Imported by icache_refill_ctrl.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    REQ1,
    FILL,
    HOLD
  } state_e;

  localparam int BLK_OFF_W = 3;
  localparam int WORD_W    = 32;
  localparam int BLK_W     = 64;
  localparam int CNT_W     = 20;

  function automatic logic [WORD_W-1:0] blk_base(
    input logic [WORD_W-1:0] pc
  );
    return {pc[WORD_W-1:BLK_OFF_W], {BLK_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_refill_ctrl.sv
// Two-beat miss refill FSM for the 2-word instruction cache.
// Optional fill/stall statistics: define REFILL_STATS_EN.
import icache_pkg::*;

module icache_refill_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [WORD_W-1:0]   PC,
  input  logic                NOT_JUMPED,
  input  logic                HitWrite,
  output logic                MEM_REQ,
  output logic [WORD_W-1:0]   MEM_ADDR,
  input  logic                MEM_ACK,
  input  logic [WORD_W-1:0]   MEM_RDATA,
  output logic                Access_MM,
  output logic [BLK_W-1:0]    Data_MM,
  output logic                BUSY,
  output logic                ERR,
  output logic [CNT_W-1:0]    CNT_REFILL,
  output logic [CNT_W-1:0]    CNT_STALL
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e              r_state;
  logic [WORD_W-1:0]   r_base;
  logic [WORD_W-1:0]   r_addr;
  logic                r_req;
  logic [BLK_W-1:0]    r_data;
  logic                r_err;
  logic [15:0]         r_timer;

  logic w_miss;
  logic w_match;
  logic w_tmo;
  logic w_fill;

  assign w_miss  = NOT_JUMPED & ~HitWrite & ~r_err;
  assign w_match = NOT_JUMPED & (blk_base(PC) == r_base);
  assign w_tmo   = (r_timer == TMO_LAST);
  assign w_fill  = (r_state == FILL) & w_match;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= IDLE;
      r_base  <= '0;
      r_addr  <= '0;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_timer <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_base  <= blk_base(PC);
            r_addr  <= blk_base(PC);
            r_req   <= 1'b1;
            r_timer <= '0;
            r_state <= REQ0;
          end
        end
        REQ0: begin
          // An ACK in the last allowed cycle still completes the beat
          if (MEM_ACK) begin
            r_data[63:32] <= MEM_RDATA;
            r_addr        <= r_base + 32'd4;
            r_timer       <= '0;
            r_state       <= REQ1;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_req   <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        REQ1: begin
          if (MEM_ACK) begin
            r_data[31:0] <= MEM_RDATA;
            r_req        <= 1'b0;
            r_timer      <= '0;
            r_state      <= FILL;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_req   <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        FILL: begin
          r_state <= w_match ? HOLD : IDLE;
        end
        HOLD: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign MEM_REQ   = r_req;
  assign MEM_ADDR  = r_addr;
  assign Data_MM   = r_data;
  assign ERR       = r_err;
  assign BUSY      = (r_state != IDLE);
  assign Access_MM = w_fill;

`ifdef REFILL_STATS_EN
  logic [CNT_W-1:0] r_cnt_refill;
  logic [CNT_W-1:0] r_cnt_stall;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt_refill <= '0;
      r_cnt_stall  <= '0;
    end else begin
      if (w_fill && (r_cnt_refill != '1))
        r_cnt_refill <= r_cnt_refill + 1'b1;
      if (BUSY && (r_cnt_stall != '1))
        r_cnt_stall <= r_cnt_stall + 1'b1;
    end
  end

  assign CNT_REFILL = r_cnt_refill;
  assign CNT_STALL  = r_cnt_stall;
`else
  assign CNT_REFILL = '0;
  assign CNT_STALL  = '0;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl (TIMEOUT=8).
// Inputs change on negedge right after that cycle's outputs are checked.
module tb_icache_refill_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] PC;
  logic        NOT_JUMPED;
  logic        HitWrite;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [31:0] MEM_RDATA;
  logic        Access_MM;
  logic [63:0] Data_MM;
  logic        BUSY;
  logic        ERR;
  logic [19:0] CNT_REFILL;
  logic [19:0] CNT_STALL;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] W0 = 32'hA1A2_A3A4;
  localparam logic [31:0] W1 = 32'hB1B2_B3B4;
  localparam logic [31:0] W2 = 32'hC1C2_C3C4;
  localparam logic [31:0] W3 = 32'hD1D2_D3D4;

  always #5 CLK = ~CLK;

  icache_refill_ctrl #(.TIMEOUT(8)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .PC         (PC),
    .NOT_JUMPED (NOT_JUMPED),
    .HitWrite   (HitWrite),
    .MEM_REQ    (MEM_REQ),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_ACK    (MEM_ACK),
    .MEM_RDATA  (MEM_RDATA),
    .Access_MM  (Access_MM),
    .Data_MM    (Data_MM),
    .BUSY       (BUSY),
    .ERR        (ERR),
    .CNT_REFILL (CNT_REFILL),
    .CNT_STALL  (CNT_STALL)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cnt_chk(input string tag, input int refill, input int stall);
`ifdef REFILL_STATS_EN
    chk({tag, "_refill"}, 64'(CNT_REFILL), 64'(refill));
    chk({tag, "_stall"}, 64'(CNT_STALL), 64'(stall));
`else
    chk({tag, "_refill"}, 64'(CNT_REFILL), 64'd0);
    chk({tag, "_stall"}, 64'(CNT_STALL), 64'd0);
    if (refill < 0 || stall < 0) $display("note: negative count");
`endif
  endtask

  initial begin
    RESET_N    = 1'b0;
    PC         = '0;
    NOT_JUMPED = 1'b0;
    HitWrite   = 1'b1;
    MEM_ACK    = 1'b0;
    MEM_RDATA  = '0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_req", 64'(MEM_REQ), 64'd0);
    chk("rst_addr", 64'(MEM_ADDR), 64'd0);
    chk("rst_acc", 64'(Access_MM), 64'd0);
    chk("rst_data", Data_MM, 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_err", 64'(ERR), 64'd0);
    cnt_chk("rst", 0, 0);
    RESET_N = 1'b1;

    // 1: zero-wait refill
    @(negedge CLK);
    PC = 32'h0040_0010; NOT_JUMPED = 1'b1; HitWrite = 1'b0;
    @(negedge CLK);
    chk("t1_req0", 64'(MEM_REQ), 64'd1);
    chk("t1_addr0", 64'(MEM_ADDR), 64'h0040_0010);
    chk("t1_busy", 64'(BUSY), 64'd1);
    MEM_ACK = 1'b1; MEM_RDATA = W0;
    @(negedge CLK);
    chk("t1_req1", 64'(MEM_REQ), 64'd1);
    chk("t1_addr1", 64'(MEM_ADDR), 64'h0040_0014);
    chk("t1_acc_early", 64'(Access_MM), 64'd0);
    MEM_RDATA = W1;
    @(negedge CLK);
    chk("t1_acc", 64'(Access_MM), 64'd1);
    chk("t1_data", Data_MM, {W0, W1});
    chk("t1_req_off", 64'(MEM_REQ), 64'd0);
    MEM_ACK = 1'b0; HitWrite = 1'b1;
    @(negedge CLK);
    chk("t1_hold_acc", 64'(Access_MM), 64'd0);
    chk("t1_hold_busy", 64'(BUSY), 64'd1);
    @(negedge CLK);
    chk("t1_idle", 64'(BUSY), 64'd0);
    cnt_chk("t1", 1, 4);

    // 2: four wait cycles per beat
    PC = 32'h0040_0108; HitWrite = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge CLK);
      chk("t2_req0_wait", 64'(MEM_REQ), 64'd1);
      chk("t2_addr0_wait", 64'(MEM_ADDR), 64'h0040_0108);
      HitWrite = 1'b1;
    end
    @(negedge CLK);
    chk("t2_addr0", 64'(MEM_ADDR), 64'h0040_0108);
    MEM_ACK = 1'b1; MEM_RDATA = W2;
    @(negedge CLK);
    chk("t2_addr1", 64'(MEM_ADDR), 64'h0040_010C);
    MEM_ACK = 1'b0;
    for (int i = 7; i <= 9; i++) begin
      @(negedge CLK);
      chk("t2_req1_wait", 64'(MEM_REQ), 64'd1);
      chk("t2_addr1_wait", 64'(MEM_ADDR), 64'h0040_010C);
      chk("t2_acc_wait", 64'(Access_MM), 64'd0);
    end
    @(negedge CLK);
    chk("t2_req1_last", 64'(MEM_REQ), 64'd1);
    MEM_ACK = 1'b1; MEM_RDATA = W3;
    @(negedge CLK);
    chk("t2_acc", 64'(Access_MM), 64'd1);
    chk("t2_data", Data_MM, {W2, W3});
    MEM_ACK = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("t2_idle", 64'(BUSY), 64'd0);
    cnt_chk("t2", 2, 16);

    // 3: redirect while second beat is outstanding
    PC = 32'h0040_0020; HitWrite = 1'b0;
    @(negedge CLK);
    chk("t3_addr0", 64'(MEM_ADDR), 64'h0040_0020);
    MEM_ACK = 1'b1; MEM_RDATA = W1;
    @(negedge CLK);
    chk("t3_addr1", 64'(MEM_ADDR), 64'h0040_0024);
    PC = 32'h0040_0100; MEM_RDATA = W0;
    @(negedge CLK);
    chk("t3_acc_drop", 64'(Access_MM), 64'd0);
    chk("t3_fill_busy", 64'(BUSY), 64'd1);
    chk("t3_req_off", 64'(MEM_REQ), 64'd0);
    MEM_ACK = 1'b0; HitWrite = 1'b1;
    @(negedge CLK);
    chk("t3_idle", 64'(BUSY), 64'd0);
    cnt_chk("t3", 2, 19);

    // 4: memory never answers
    PC = 32'h0040_0200; HitWrite = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      chk("t4_req_wait", 64'(MEM_REQ), 64'd1);
      chk("t4_err_wait", 64'(ERR), 64'd0);
    end
    @(negedge CLK);
    chk("t4_err", 64'(ERR), 64'd1);
    chk("t4_req_off", 64'(MEM_REQ), 64'd0);
    chk("t4_busy_off", 64'(BUSY), 64'd0);
    @(negedge CLK);
    chk("t4_ignored_req", 64'(MEM_REQ), 64'd0);
    chk("t4_ignored_busy", 64'(BUSY), 64'd0);
    chk("t4_err_sticky", 64'(ERR), 64'd1);
    HitWrite = 1'b1;
    RESET_N = 1'b0;
    #1;
    chk("t4_err_clr", 64'(ERR), 64'd0);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("t4_idle", 64'(BUSY), 64'd0);

    // 5: asynchronous reset in REQ1
    PC = 32'h0040_0300; HitWrite = 1'b0;
    @(negedge CLK);
    chk("t5_addr0", 64'(MEM_ADDR), 64'h0040_0300);
    MEM_ACK = 1'b1; MEM_RDATA = W3;
    @(negedge CLK);
    chk("t5_req1", 64'(MEM_REQ), 64'd1);
    chk("t5_addr1", 64'(MEM_ADDR), 64'h0040_0304);
    MEM_ACK = 1'b0;
    #1 RESET_N = 1'b0;
    #1;
    chk("t5_rst_req", 64'(MEM_REQ), 64'd0);
    chk("t5_rst_busy", 64'(BUSY), 64'd0);
    chk("t5_rst_acc", 64'(Access_MM), 64'd0);
    chk("t5_rst_data", Data_MM, 64'd0);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("t5_restart_req", 64'(MEM_REQ), 64'd1);
    chk("t5_restart_addr", 64'(MEM_ADDR), 64'h0040_0300);
    MEM_ACK = 1'b1; MEM_RDATA = W0;
    @(negedge CLK);
    chk("t5_restart_addr1", 64'(MEM_ADDR), 64'h0040_0304);
    MEM_RDATA = W1;
    @(negedge CLK);
    chk("t5_acc", 64'(Access_MM), 64'd1);
    chk("t5_data", Data_MM, {W0, W1});
    MEM_ACK = 1'b0; HitWrite = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk("t5_idle", 64'(BUSY), 64'd0);

    // 6: top-of-memory block, miss kept asserted through HOLD
    PC = 32'hFFFF_FFFC; HitWrite = 1'b0;
    @(negedge CLK);
    chk("t6_addr0", 64'(MEM_ADDR), 64'hFFFF_FFF8);
    MEM_ACK = 1'b1; MEM_RDATA = W2;
    @(negedge CLK);
    chk("t6_addr1", 64'(MEM_ADDR), 64'hFFFF_FFFC);
    MEM_RDATA = W3;
    @(negedge CLK);
    chk("t6_acc", 64'(Access_MM), 64'd1);
    chk("t6_data", Data_MM, {W2, W3});
    MEM_ACK = 1'b0;
    @(negedge CLK);
    chk("t6_hold_busy", 64'(BUSY), 64'd1);
    chk("t6_hold_req", 64'(MEM_REQ), 64'd0);
    chk("t6_hold_acc", 64'(Access_MM), 64'd0);
    @(negedge CLK);
    chk("t6_idle_busy", 64'(BUSY), 64'd0);
    chk("t6_idle_req", 64'(MEM_REQ), 64'd0);
    @(negedge CLK);
    chk("t6_retrig_req", 64'(MEM_REQ), 64'd1);
    chk("t6_retrig_addr", 64'(MEM_ADDR), 64'hFFFF_FFF8);
    HitWrite = 1'b1;
    RESET_N = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
